p_divider: RTL and testbench

- Sequential unsigned restoring divider. It is the inverse companion to the team's pipelined multiplier: it divides a 2*WIDTH-bit product-sized dividend by a WIDTH-bit divisor.
- It produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock.
- It shares the multiplier's enable/ready style so both blocks can sit side by side in the same arithmetic datapath.

---
 rtl/p_divider_if.sv | 23 ++
 rtl/p_divider.sv | 115 +++++++++++
 tb/tb_p_divider.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/p_divider_if.sv
// Handshake and data bundle for the sequential divider.
// The master drives the operands and the request, and the slave returns the result.
interface p_divider_if #(parameter int WIDTH = 8);
  logic               enable;
  logic               start;
  logic [2*WIDTH-1:0] dataa;
  logic [WIDTH-1:0]   datab;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;

  modport master (
    output enable, start, dataa, datab,
    input  busy, ready, quotient, remainder, div_by_zero
  );

  modport slave (
    input  enable, start, dataa, datab,
    output busy, ready, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/p_divider.sv
// Unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// It produces one quotient bit per enabled clock. A zero divisor finishes
// immediately and sets div_by_zero.
module p_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  p_divider_if.slave  bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   prem;      // partial remainder
  logic [DW-1:0]    dvd;       // dividend in, quotient bits shifted in at the bottom
  logic [WIDTH-1:0] dvs;       // latched divisor
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy, ready;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             neg;
  logic [WIDTH:0]   prem_n;
  logic [DW-1:0]    dvd_n;

  // A start is only taken outside CALC, and only on an enabled cycle.
  assign accept = bus.enable && bus.start && (state != CALC);

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  // The extra top bit of trial is the borrow, and it marks a negative result.
  always_comb begin
    shifted = {prem[WIDTH-1:0], dvd[DW-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    neg     = trial[WIDTH+1];
    prem_n  = neg ? shifted : trial[WIDTH:0];
    dvd_n   = {dvd[DW-2:0], ~neg};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and status decode.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_n = (bus.datab == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (bus.enable && cnt == '0) state_n = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (accept)          state_n = (bus.datab == '0) ? DONE : CALC;
        else if (bus.enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers. Results hold until
  // the next result is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      prem        <= '0;
      dvd         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (bus.enable) begin
      if (accept) begin
        dvs <= bus.datab;
        if (bus.datab == '0) begin
          quotient    <= '1;
          remainder   <= bus.dataa[WIDTH-1:0];
          div_by_zero <= 1'b1;
        end else begin
          prem <= '0;
          dvd  <= bus.dataa;
          cnt  <= CW'(DW - 1);
        end
      end else if (state == CALC) begin
        prem <= prem_n;
        dvd  <= dvd_n;
        cnt  <= cnt - CW'(1);
        if (cnt == '0) begin
          quotient    <= dvd_n;
          remainder   <= prem_n[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.ready       = ready;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_p_divider.sv
// Directed bench for p_divider (WIDTH=8). A result queue filled from plain
// '/' and '%' is checked against the outputs on every cycle. Hand-computed
// literals and latency/busy counts pin the expected values.
module tb_p_divider;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           z;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  res_t pend[$];
  res_t cur;
  logic rdy_d;

  p_divider_if #(.WIDTH(W)) ifc ();

  p_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition.
  function automatic res_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    res_t x;
    if (b == 0) begin
      x.q = '1;
      x.r = a[W-1:0];
      x.z = 1'b1;
    end else begin
      x.q = a / b;
      x.r = W'(a % b);
      x.z = 1'b0;
    end
    return x;
  endfunction

  // Compare process. A new expected result is taken on each rising ready. The
  // outputs must match the latest result on every cycle, including the holds
  // between results. Reset discards anything still pending.
  initial begin
    cur   = '{q: '0, r: '0, z: 1'b0};
    rdy_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        cur   = '{q: '0, r: '0, z: 1'b0};
        rdy_d = 1'b0;
      end else begin
        if (ifc.ready && !rdy_d) begin
          if (pend.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: got ready=1, expected no pending request (t=%0t)", $time);
          end else begin
            cur = pend.pop_front();
          end
        end
        chk("model_quotient", 32'(ifc.quotient), 32'(cur.q));
        chk("model_remainder", 32'(ifc.remainder), 32'(cur.r));
        chk("model_dbz", 32'(ifc.div_by_zero), 32'(cur.z));
        rdy_d = ifc.ready;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive a request that will be accepted on the next edge.
  task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b);
    ifc.start = 1'b1;
    ifc.dataa = a;
    ifc.datab = b;
    pend.push_back(model(a, b));
  endtask

  // Wait for ready. n counts cycles from the start-driving cycle, so ready
  // in cycle n means it rose on edge n after the accepting edge (edge 1).
  task automatic wait_ready(inout int n, inout int nb);
    while (!ifc.ready && n < 80) begin
      if (ifc.busy) nb++;
      cyc();
      n++;
    end
  endtask

  task automatic run(input logic [2*W-1:0] a, input logic [W-1:0] b,
                     input int lat, input int bsy,
                     input logic [2*W-1:0] lq, input logic [W-1:0] lr, input logic lz);
    int n, nb;
    issue(a, b);
    cyc();
    ifc.start = 1'b0;
    n  = 1;
    nb = 0;
    wait_ready(n, nb);
    chk("latency", n, lat);
    chk("busy_cycles", nb, bsy);
    chk("lit_quotient", 32'(ifc.quotient), 32'(lq));
    chk("lit_remainder", 32'(ifc.remainder), 32'(lr));
    chk("lit_dbz", 32'(ifc.div_by_zero), 32'(lz));
  endtask

  initial begin
    int n, nb;
    ifc.enable = 1'b1;
    ifc.start  = 1'b0;
    ifc.dataa  = '0;
    ifc.datab  = '0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_ready", 32'(ifc.ready), 0);
    chk("rst_quotient", 32'(ifc.quotient), 0);
    chk("rst_remainder", 32'(ifc.remainder), 0);
    chk("rst_dbz", 32'(ifc.div_by_zero), 0);
    cyc();

    // Basic division from IDLE: 1000 = 7*142 + 6.
    run(16'd1000, 8'd7, 17, 16, 16'd142, 8'd6, 1'b0);
    cyc();
    cyc();
    run(16'hFFFF, 8'hFF, 17, 16, 16'd257, 8'd0, 1'b0);
    cyc();
    run(16'd3, 8'd200, 17, 16, 16'd0, 8'd3, 1'b0);
    cyc();

    // A zero divisor finishes in one cycle. The next division clears the flag.
    run(16'd5, 8'd0, 1, 0, 16'hFFFF, 8'd5, 1'b1);
    run(16'd1000, 8'd7, 17, 16, 16'd142, 8'd6, 1'b0);
    cyc();

    // Stall mid-CALC for 4 cycles. Starts with other operands are ignored.
    issue(16'd1000, 8'd7);
    cyc();
    ifc.start = 1'b0;
    n  = 1;
    nb = 0;
    repeat (4) begin cyc(); n++; end
    ifc.enable = 1'b0;
    ifc.start  = 1'b1;
    ifc.dataa  = 16'd50000;
    ifc.datab  = 8'd3;
    repeat (4) begin cyc(); n++; end
    chk("stall_busy", 32'(ifc.busy), 1);
    chk("stall_ready", 32'(ifc.ready), 0);
    ifc.enable = 1'b1;
    cyc();
    n++;
    ifc.start = 1'b0;
    wait_ready(n, nb);
    chk("stall_latency", n, 21);
    chk("stall_quotient", 32'(ifc.quotient), 142);
    chk("stall_remainder", 32'(ifc.remainder), 6);

    // Start during the DONE cycle is accepted. The old result holds until then.
    run(16'd100, 8'd9, 17, 16, 16'd11, 8'd1, 1'b0);
    cyc();

    // Reset in cycle 8 of a division abandons it.
    issue(16'd1000, 8'd7);
    cyc();
    ifc.start = 1'b0;
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(ifc.busy), 0);
    chk("mid_rst_ready", 32'(ifc.ready), 0);
    chk("mid_rst_quotient", 32'(ifc.quotient), 0);
    chk("mid_rst_remainder", 32'(ifc.remainder), 0);
    nb = 0;
    repeat (20) begin
      if (ifc.ready) nb++;
      cyc();
    end
    chk("mid_rst_no_ready", nb, 0);
    run(16'd1000, 8'd7, 17, 16, 16'd142, 8'd6, 1'b0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
